// File: rtl/playseq_pkg.sv
// Shared PlaySeq definitions: default widths, reader state encoding, one-hot button codes
// and the counter-width helper.
package playseq_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_P_FETCH   = 3'd1;
  localparam logic [2:0] ST_P_SHOW    = 3'd2;
  localparam logic [2:0] ST_P_GAP     = 3'd3;
  localparam logic [2:0] ST_C_FETCH   = 3'd4;
  localparam logic [2:0] ST_C_WAIT    = 3'd5;
  localparam logic [2:0] ST_C_RELEASE = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE,
    StPFetch   = ST_P_FETCH,
    StPShow    = ST_P_SHOW,
    StPGap     = ST_P_GAP,
    StCFetch   = ST_C_FETCH,
    StCWait    = ST_C_WAIT,
    StCRelease = ST_C_RELEASE,
    StDone     = ST_DONE
  } seq_state_e;

  localparam logic [3:0] CODE_BTN0 = 4'b0001;
  localparam logic [3:0] CODE_BTN1 = 4'b0010;
  localparam logic [3:0] CODE_BTN2 = 4'b0100;
  localparam logic [3:0] CODE_BTN3 = 4'b1000;

  // Width able to hold the largest of three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module tick_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/seq_reader.sv
// Sequence ROM reader: plays entries 0..limite on the LEDs, then checks button presses against them.
// Optional press timeout in the check phase is enabled with SEQ_READER_TIMEOUT_EN.
module seq_reader
  import playseq_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned SHOW_CYCLES    = 1000,
  parameter int unsigned GAP_CYCLES     = 250,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] botoes,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              acertou,
  output logic              errou,
  output logic              timeout
);

  localparam int unsigned CntW = cnt_width(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] ShowLoad = CntW'(SHOW_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic              fetch_q, fetch_d;
  logic [DATA_W-1:0] want;

  logic            tk_load, tk_en, tk_zero;
  logic [CntW-1:0] tk_val;

`ifdef SEQ_READER_TIMEOUT_EN
  localparam logic [CntW-1:0] ToLoad = CntW'(TIMEOUT_CYCLES - 1);
  logic to_q, to_d;
  logic to_load, to_en, to_zero;
`endif

  // mem_data is valid in the cycle right after a fetch state.
  assign fetch_d = (state_q == StPFetch) || (state_q == StCFetch);
  assign want    = fetch_q ? mem_data : exp_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lim_d   = lim_q;
    leds_d  = leds_q;
    exp_d   = exp_q;
    ok_d    = ok_q;
    err_d   = err_q;
    tk_load = 1'b0;
    tk_val  = '0;
    tk_en   = 1'b0;
`ifdef SEQ_READER_TIMEOUT_EN
    to_d    = to_q;
    to_load = 1'b0;
    to_en   = 1'b0;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (iniciar) begin
          lim_d   = limite;
          addr_d  = '0;
          ok_d    = 1'b0;
          err_d   = 1'b0;
`ifdef SEQ_READER_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          state_d = StPFetch;
        end
      end
      StPFetch: state_d = StPShow;
      StPShow: begin
        if (fetch_q) begin
          leds_d  = mem_data;
          tk_load = 1'b1;
          tk_val  = ShowLoad;
        end else if (tk_zero) begin
          leds_d  = '0;
          tk_load = 1'b1;
          tk_val  = GapLoad;
          state_d = StPGap;
        end else begin
          tk_en = 1'b1;
        end
      end
      StPGap: begin
        if (tk_zero) begin
          if (addr_q == lim_q) begin
            addr_d  = '0;
            state_d = StCFetch;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StPFetch;
          end
        end else begin
          tk_en = 1'b1;
        end
      end
      StCFetch: begin
`ifdef SEQ_READER_TIMEOUT_EN
        to_load = 1'b1;
`endif
        state_d = StCWait;
      end
      StCWait: begin
        if (fetch_q) exp_d = mem_data;
        // Whole-word compare: a multi-bit press can never equal a one-hot code.
        if (botoes != '0) begin
          if (botoes == want) begin
            state_d = StCRelease;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end else begin
`ifdef SEQ_READER_TIMEOUT_EN
          if (to_zero) begin
            err_d   = 1'b1;
            to_d    = 1'b1;
            state_d = StDone;
          end else begin
            to_en = 1'b1;
          end
`endif
        end
      end
      StCRelease: begin
        if (botoes == '0) begin
          if (addr_q == lim_q) begin
            ok_d    = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StCFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lim_q   <= '0;
      leds_q  <= '0;
      exp_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lim_q   <= lim_d;
      leds_q  <= leds_d;
      exp_q   <= exp_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      fetch_q <= fetch_d;
    end
  end

  tick_counter #(
    .W (CntW)
  ) u_phase_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (tk_load),
    .load_val_i (tk_val),
    .en_i       (tk_en),
    .zero_o     (tk_zero)
  );

`ifdef SEQ_READER_TIMEOUT_EN
  tick_counter #(
    .W (CntW)
  ) u_timeout_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (to_load),
    .load_val_i (ToLoad),
    .en_i       (to_en),
    .zero_o     (to_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_q <= 1'b0;
    end else begin
      to_q <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign mem_addr = addr_q;
  assign leds     = leds_q;
  assign acertou  = ok_q;
  assign errou    = err_q;
  assign ocupado  = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_seq_reader.sv
// Scoreboard bench for seq_reader with a behavioural sequence ROM; honours SEQ_READER_TIMEOUT_EN.
module tb_seq_reader;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TO   = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] limite = '0;
  logic [3:0] botoes = '0;
  logic [3:0] mem_data = '0;
  logic [3:0] mem_addr, leds;
  logic       ocupado, acertou, errou, timeout;

  typedef struct {
    logic [3:0] val;
    logic [3:0] addr;
    bit         first;
  } led_exp_t;

  typedef struct {
    bit         ok;
    bit         err;
    bit         to;
    logic [3:0] addr;
    int         lat;
  } done_exp_t;

  led_exp_t  led_q[$];
  done_exp_t done_q[$];
  int        n_total = 0;
  int        n_pass = 0;

  always #5 clock = ~clock;

  function automatic logic [3:0] rom_word(input logic [3:0] a);
    if (a < 4) return 4'b0001;
    else if (a < 8) return 4'b0010;
    else if (a < 12) return 4'b0100;
    else return 4'b1000;
  endfunction

  always @(posedge clock) mem_data <= rom_word(mem_addr);

  seq_reader #(
    .ADDR_W         (4),
    .DATA_W         (4),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .limite   (limite),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .botoes   (botoes),
    .leds     (leds),
    .ocupado  (ocupado),
    .acertou  (acertou),
    .errou    (errou),
    .timeout  (timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: consumes expectations as lit runs end and as ocupado falls.
  initial begin : monitor
    int         dark;
    int         dark_before;
    int         lit_len;
    logic [3:0] lit_val;
    logic [3:0] lit_addr;
    bit         prev_busy;
    dark = 0; dark_before = 0; lit_len = 0; lit_val = '0; lit_addr = '0; prev_busy = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        lit_len = 0; dark = 0; prev_busy = 0;
        continue;
      end
      if (prev_busy && !ocupado) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("done_acertou", int'(acertou), int'(e.ok));
          check("done_errou", int'(errou), int'(e.err));
          check("done_timeout", int'(timeout), int'(e.to));
          check("done_mem_addr", int'(mem_addr), int'(e.addr));
          if (e.lat >= 0) check("done_latency", dark, e.lat);
        end
      end
      prev_busy = ocupado;
      if (leds != '0) begin
        if (lit_len == 0) begin
          lit_val = leds; lit_addr = mem_addr; dark_before = dark;
        end else if (leds != lit_val) begin
          check("led_stable", int'(leds), int'(lit_val));
        end
        lit_len++;
        dark = 0;
      end else begin
        if (lit_len != 0) begin
          if (led_q.size() == 0) begin
            check("unexpected_led", 1, 0);
          end else begin
            led_exp_t e;
            e = led_q.pop_front();
            check("led_value", int'(lit_val), int'(e.val));
            check("led_addr", int'(lit_addr), int'(e.addr));
            check("led_show_len", lit_len, SHOW);
            // Dark between entries: gap plus the fetch cycle and the ROM latency cycle.
            if (!e.first) check("led_gap_len", dark_before, GAP + 2);
          end
          lit_len = 0;
        end
        dark++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start(input logic [3:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      led_q.push_back('{val: rom_word(4'(i)), addr: 4'(i), first: (i == 0)});
    end
    limite = l;
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    limite = 4'($urandom);
  endtask

  task automatic wait_playback();
    int b = 0;
    while (led_q.size() != 0 && b < 2000) begin
      tick(1);
      b++;
    end
    if (b >= 2000) check("playback_bound", led_q.size(), 0);
  endtask

  task automatic wait_idle(input int bound);
    int b = 0;
    while (ocupado && b < bound) begin
      tick(1);
      b++;
    end
    check("reached_done", int'(ocupado), 0);
    tick(2);
  endtask

  task automatic run_check(input logic [3:0] l, input logic [3:0] presses[16], input bit poke);
    int stop = int'(l);
    bit ok = 1;
    for (int i = 0; i <= int'(l); i++) begin
      if (presses[i] != rom_word(4'(i))) begin
        stop = i; ok = 0;
        break;
      end
    end
    done_q.push_back('{ok: ok, err: !ok, to: 0, addr: 4'(stop), lat: -1});
    start(l);
    wait_playback();
    for (int i = 0; i <= stop; i++) begin
      tick($urandom_range(3, 6));
      if (poke && i == 1) begin
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(3);
      end
      botoes = presses[i];
      if (!ok && i == stop) begin
        tick(1);
        check("err_next_cycle", int'(ocupado), 0);
      end else begin
        tick($urandom_range(1, 3));
      end
      botoes = '0;
    end
    wait_idle(50);
  endtask

  initial begin : stimulus
    logic [3:0] p[16];
    tick(3);
    check("rst_leds", int'(leds), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_flags", int'({acertou, errou, timeout}), 0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 16; i++) p[i] = rom_word(4'(i));
    run_check(4'd5, p, 1'b1);
    p[2] = 4'b0010;
    run_check(4'd5, p, 1'b0);
    p[2] = rom_word(4'd2);
    p[0] = 4'b0011;
    run_check(4'd0, p, 1'b0);
    p[0] = rom_word(4'd0);
    run_check(4'd15, p, 1'b0);

    // Reset while entry 3 is lit.
    start(4'd5);
    begin
      int b = 0;
      while (!(mem_addr == 4'd3 && leds != '0) && b < 500) begin
        tick(1);
        b++;
      end
      check("reach_addr3", int'(mem_addr), 3);
    end
    reset = 1'b1;
    #1;
    check("midrst_leds", int'(leds), 0);
    check("midrst_mem_addr", int'(mem_addr), 0);
    check("midrst_ocupado", int'(ocupado), 0);
    led_q.delete();
    tick(2);
    reset = 1'b0;
    tick(2);

    for (int k = 0; k < 6; k++) begin
      logic [3:0] l;
      l = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        p[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : rom_word(4'(i));
      end
      run_check(l, p, k == 0);
    end

`ifdef SEQ_READER_TIMEOUT_EN
    done_q.push_back('{ok: 0, err: 1, to: 1, addr: 4'd0, lat: GAP + 1 + TO});
    start(4'd1);
    wait_playback();
    wait_idle(200);
`else
    start(4'd1);
    wait_playback();
    tick(1000);
    check("no_timeout_busy", int'(ocupado), 1);
    check("no_timeout_errou", int'(errou), 0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
`endif

    tick(5);
    check("led_queue_empty", led_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
